// File: rtl/spi_pkg.sv
// Shared SPI master types: FSM state enum, default parameters,
// and a helper sizing the slave-select index port.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CPHA_DLY,
    P0,
    P1
  } state_t;

  localparam int WORD_LEN_DEF   = 8;
  localparam int NUM_SLAVES_DEF = 4;
  localparam int DVSR_W_DEF     = 16;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: load_i captures dvsr_i, then tick_o marks the
// last cycle of every (dvsr+1)-cycle window, reloading itself.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int DvsrWidth = DVSR_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [DvsrWidth-1:0] dvsr_i,
  output logic                 tick_o
);

  logic [DvsrWidth-1:0] dvsr_q;
  logic [DvsrWidth-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      dvsr_q <= dvsr_i;
      cnt_q  <= dvsr_i;
    end else if (cnt_q == '0) begin
      cnt_q  <= dvsr_q;
    end else begin
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_master_mcs.sv
// SPI master, all four modes, MSB/LSB first, multi slave-select
// with burst hold. Ports: word/divisor/mode/select in, SPI pins out.
module spi_master_mcs
  import spi_pkg::*;
#(
  parameter int WordLength = WORD_LEN_DEF,
  parameter int NumSlaves  = NUM_SLAVES_DEF,
  parameter int DvsrWidth  = DVSR_W_DEF,
  localparam int SelW      = sel_width(NumSlaves)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WordLength-1:0] din_i,
  input  logic [DvsrWidth-1:0]  dvsr_i,
  input  logic                  start_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  lsb_first_i,
  input  logic [SelW-1:0]       ss_sel_i,
  input  logic                  hold_ss_i,
  output logic [WordLength-1:0] dout_o,
  output logic                  spi_done_tick_o,
  output logic                  ready_o,
  output logic                  sclk_o,
  output logic                  mosi_o,
  input  logic                  miso_i,
  output logic [NumSlaves-1:0]  ss_n_o
);

  localparam int CntW = $clog2(WordLength);
  localparam logic [CntW-1:0] LastBit =
    CntW'(WordLength - 1);

  state_t state_q, state_d;
  logic accept, last, tick, inv, lvl_d;
  logic [WordLength-1:0] tx_q, rx_q, dout_q;
  logic [CntW-1:0] bit_q;
  logic cpol_q, cpha_q, lsb_q, hold_q;
  logic done_q, sclk_q;
  logic [NumSlaves-1:0] ss_q;

  // Out-of-range selects decode to all ones.
  function automatic logic [NumSlaves-1:0]
    decode(input logic [SelW-1:0] s);
    logic [NumSlaves-1:0] d;
    for (int i = 0; i < NumSlaves; i++)
      d[i] = (int'(s) != i);
    return d;
  endfunction

  spi_clk_div #(.DvsrWidth(DvsrWidth)) u_div (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (accept),
    .dvsr_i (dvsr_i),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = cpha_i ? CPHA_DLY : P0;
        end
      end
      CPHA_DLY: if (tick) state_d = P0;
      P0:       if (tick) state_d = P1;
      P1: begin
        if (tick) begin
          if (bit_q == LastBit) begin
            state_d = IDLE;
            last    = 1'b1;
          end else begin
            state_d = P0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The active half-period is P1 for cpha=0, P0 for cpha=1.
  assign inv   = cpha_q ? (state_d == P0)
                        : (state_d == P1);
  assign lvl_d = cpol_q ^ inv;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tx_q   <= '0;
      rx_q   <= '0;
      dout_q <= '0;
      bit_q  <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      lsb_q  <= 1'b0;
      hold_q <= 1'b0;
      done_q <= 1'b0;
      sclk_q <= 1'b0;
      ss_q   <= '1;
    end else begin
      done_q <= last;
      sclk_q <= (state_q == IDLE) ? cpol_i : lvl_d;
      if (accept) begin
        tx_q   <= din_i;
        cpol_q <= cpol_i;
        cpha_q <= cpha_i;
        lsb_q  <= lsb_first_i;
        hold_q <= hold_ss_i;
        bit_q  <= '0;
        ss_q   <= decode(ss_sel_i);
      end
      if (state_q == P0 && tick) begin
        rx_q <= lsb_q
          ? {miso_i, rx_q[WordLength-1:1]}
          : {rx_q[WordLength-2:0], miso_i};
      end
      if (state_q == P1 && tick) begin
        tx_q <= lsb_q ? (tx_q >> 1) : (tx_q << 1);
        if (last) begin
          dout_q <= rx_q;
          if (!hold_q) ss_q <= '1;
        end else begin
          bit_q <= bit_q + 1'b1;
        end
      end
    end
  end

  assign ready_o         = (state_q == IDLE);
  assign spi_done_tick_o = done_q;
  assign dout_o          = dout_q;
  assign sclk_o          = sclk_q;
  assign ss_n_o          = ss_q;
  assign mosi_o          = lsb_q ? tx_q[0]
                                 : tx_q[WordLength-1];

endmodule
